// File: rtl/sr_flag_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sr_flag_arbiter
//  Description : Round-robin arbiter and sequencer that shares one SR flag
//                flop between NREQ requesters. A granted set/reset request
//                is driven onto s or r as a clean HOLD_CYC-cycle pulse (never
//                s and r together). The requester then receives a one-cycle
//                acknowledge.
//                Optional build macro SR_FLAG_VERIFY_EN inserts a CHECK state
//                that compares the flop output against the requested value
//                and raises a sticky verify_err on mismatch. Without the
//                macro, flag_q is unused and verify_err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_flag_arbiter #(
    parameter int NREQ     = 4,
    parameter int HOLD_CYC = 1
) (
    input  logic            clk,
    input  logic            clear,
    input  logic [NREQ-1:0] req_set,
    input  logic [NREQ-1:0] req_rst,
    input  logic            flag_q,
    output logic            s,
    output logic            r,
    output logic [NREQ-1:0] ack,
    output logic            busy,
    output logic            err_conflict,
    output logic            verify_err
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = 4;

    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);
    localparam logic [IDX_W:0]   NREQ_EXT  = (IDX_W+1)'(NREQ);

`ifdef SR_FLAG_VERIFY_EN
    localparam bit VERIFY_EN = 1'b1;
`else
    localparam bit VERIFY_EN = 1'b0;
`endif

    // State encoding. CHECK is only reachable when verification is built in.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [1:0]       state;
    logic [1:0]       next_state;

    logic [IDX_W-1:0] rr_ptr;      // first index searched on the next grant
    logic [IDX_W-1:0] gnt_idx;     // requester currently being served
    logic             op;          // 1 = set, 0 = reset
    logic [CNT_W-1:0] hold_cnt;    // remaining drive cycles, including current

    logic [NREQ-1:0]  eligible;
    logic             any_elig;
    logic [IDX_W-1:0] win_idx;
    logic             win_op;
    logic [IDX_W:0]   cand;

    logic             grant;
    logic             drive_next;
    logic             op_next;
    logic [IDX_W:0]   ptr_sum;

    // ------------------------------------------------------------------
    // Eligibility: exactly one of set/reset asks; both-high is a conflict
    // and is never served.
    // ------------------------------------------------------------------
    always_comb begin
        eligible = req_set ^ req_rst;
    end

    // Round-robin search from rr_ptr upward; iterating from the farthest
    // offset down lets the nearest eligible index overwrite the winner.
    always_comb begin
        any_elig = 1'b0;
        win_idx  = '0;
        win_op   = 1'b0;
        cand     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (cand >= NREQ_EXT) begin
                cand = cand - NREQ_EXT;
            end
            if (eligible[cand[IDX_W-1:0]]) begin
                any_elig = 1'b1;
                win_idx  = cand[IDX_W-1:0];
                win_op   = req_set[cand[IDX_W-1:0]];
            end
        end
    end

    // A grant is taken only from IDLE, so operations are always separated
    // by at least one idle cycle after ACK.
    always_comb begin
        grant = (state == ST_IDLE) && any_elig;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // Holds the sequencer state; clear aborts any operation in flight.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM: next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (any_elig) begin
                    next_state = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (hold_cnt == CNT_LAST) begin
                    next_state = VERIFY_EN ? ST_CHECK : ST_ACK;
                end
            end
            ST_CHECK: begin
                next_state = ST_ACK;
            end
            ST_ACK: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // FSM: output decode (acknowledge to the served requester, busy)
    always_comb begin
        ack  = '0;
        busy = (state != ST_IDLE);
        if (state == ST_ACK) begin
            ack[gnt_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Grant bookkeeping
    // ------------------------------------------------------------------
    // Pointer advance past the served requester, wrapped modulo NREQ.
    always_comb begin
        ptr_sum = {1'b0, gnt_idx} + (IDX_W+1)'(1);
        if (ptr_sum >= NREQ_EXT) begin
            ptr_sum = '0;
        end
    end

    // Latches the winner and operation, runs the hold counter and moves
    // the round-robin pointer once the operation is acknowledged.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            rr_ptr   <= '0;
            gnt_idx  <= '0;
            op       <= 1'b0;
            hold_cnt <= '0;
        end else begin
            if (grant) begin
                gnt_idx  <= win_idx;
                op       <= win_op;
                hold_cnt <= HOLD_INIT;
            end else if (state == ST_DRIVE) begin
                hold_cnt <= hold_cnt - CNT_LAST;
            end
            if (state == ST_ACK) begin
                rr_ptr <= ptr_sum[IDX_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // SR drive: registered, decoded from the state being entered so s/r
    // rise on the grant edge and fall on the edge that leaves DRIVE. Only
    // one of them can be high because they are split on a single op bit.
    // ------------------------------------------------------------------
    always_comb begin
        drive_next = (next_state == ST_DRIVE);
        op_next    = grant ? win_op : op;
    end

    // Registers the set/reset drive lines.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            s <= 1'b0;
            r <= 1'b0;
        end else begin
            s <= drive_next & op_next;
            r <= drive_next & ~op_next;
        end
    end

    // Flags, one cycle later, any requester that asked for set and reset
    // at once.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            err_conflict <= 1'b0;
        end else begin
            err_conflict <= |(req_set & req_rst);
        end
    end

    // ------------------------------------------------------------------
    // Optional readback verification
    // ------------------------------------------------------------------
`ifdef SR_FLAG_VERIFY_EN
    // Sticky mismatch between the flop output and the requested value,
    // sampled in CHECK after the drive pulse has settled.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            verify_err <= 1'b0;
        end else if ((state == ST_CHECK) && (flag_q != op)) begin
            verify_err <= 1'b1;
        end
    end
`else
    // Readback is not used in this build.
    logic unused_flag_q;
    assign unused_flag_q = flag_q;
    assign verify_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sr_flag_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr_flag_arbiter
//  Description : Self-checking bench for sr_flag_arbiter. A reference model
//                works out grants from the sampled request vectors with
//                round-robin arithmetic and queues each expected
//                acknowledge. A monitor checks s/r/busy/ack/flags on every
//                falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_flag_arbiter;

    localparam int NREQ = 4;
    localparam int HOLD = 3;
`ifdef SR_FLAG_VERIFY_EN
    localparam int VLAT = 1;
`else
    localparam int VLAT = 0;
`endif

    logic            clk   = 1'b0;
    logic            clear = 1'b1;
    logic [NREQ-1:0] req_set = '0;
    logic [NREQ-1:0] req_rst = '0;
    logic            flag_q;
    logic            s, r, busy, err_conflict, verify_err;
    logic [NREQ-1:0] ack;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sr_flag_arbiter #(.NREQ(NREQ), .HOLD_CYC(HOLD)) dut (
        .clk          (clk),
        .clear        (clear),
        .req_set      (req_set),
        .req_rst      (req_rst),
        .flag_q       (flag_q),
        .s            (s),
        .r            (r),
        .ack          (ack),
        .busy         (busy),
        .err_conflict (err_conflict),
        .verify_err   (verify_err)
    );

    // ------------------------------------------------------------------
    // SR flop model feeding flag_q (optionally tied low)
    // ------------------------------------------------------------------
    logic flag_mem = 1'b0;
    logic tie_low  = 1'b0;
    assign flag_q = tie_low ? 1'b0 : flag_mem;

    initial forever begin
        @(posedge clk);
        if (s)      flag_mem = 1'b1;
        else if (r) flag_mem = 1'b0;
    end

    task automatic chk(input string name, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp_v, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: edge-indexed grants from sampled requests
    // ------------------------------------------------------------------
    typedef struct {
        int idx;
        int ack_cyc;
    } txn_t;

    txn_t exp_q[$];
    int   ack_log[$];
    int   cyc       = 0;
    int   rr        = 0;
    int   next_free = 0;
    bit   cur_valid = 0;
    int   cur_k     = 0;
    bit   cur_op    = 0;
    bit   exp_err   = 0;
    int   verr_at   = -1;

    initial forever begin
        @(posedge clk or posedge clear);
        if (clear) begin
            exp_q.delete();
            cur_valid = 0;
            rr        = 0;
            next_free = 0;
            exp_err   = 0;
            verr_at   = -1;
        end else begin
            bit found;
            int idx;
            cyc++;
            exp_err = |(req_set & req_rst);
            found   = 0;
            if (cyc >= next_free) begin
                for (int o = 0; o < NREQ; o++) begin
                    idx = (rr + o) % NREQ;
                    if (!found && (req_set[idx] != req_rst[idx])) begin
                        found     = 1;
                        cur_valid = 1;
                        cur_k     = cyc;
                        cur_op    = req_set[idx];
                        exp_q.push_back('{idx, cyc + HOLD + VLAT});
                        rr        = (idx + 1) % NREQ;
                        next_free = cyc + HOLD + 2 + VLAT;
                        if (VLAT == 1 && tie_low && cur_op && verr_at < 0)
                            verr_at = cyc + HOLD + 1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compare DUT outputs with the model on every falling edge
    // ------------------------------------------------------------------
    initial forever begin
        bit              in_drive;
        bit              exp_busy;
        bit              exp_verr;
        logic [NREQ-1:0] exp_ack;
        @(negedge clk);
        in_drive = cur_valid && (cyc >= cur_k) && (cyc < cur_k + HOLD);
        exp_busy = cur_valid && (cyc >= cur_k) && (cyc <= cur_k + HOLD + VLAT);
        exp_verr = (verr_at >= 0) && (cyc >= verr_at);
        exp_ack  = '0;
        if (exp_q.size() > 0 && exp_q[0].ack_cyc == cyc) begin
            exp_ack[exp_q[0].idx] = 1'b1;
            void'(exp_q.pop_front());
        end
        for (int i = 0; i < NREQ; i++) if (ack[i]) ack_log.push_back(i);
        chk("s",            int'(s),            int'(in_drive && cur_op));
        chk("r",            int'(r),            int'(in_drive && !cur_op));
        chk("s_and_r",      int'(s & r),        0);
        chk("busy",         int'(busy),         int'(exp_busy));
        chk("ack",          int'(ack),          int'(exp_ack));
        chk("err_conflict", int'(err_conflict), int'(exp_err));
        chk("verify_err",   int'(verify_err),   int'(exp_verr));
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    bit auto_drop = 1;

    task automatic step();
        @(posedge clk);
        #1;
        if (auto_drop) begin
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i]) begin
                    req_set[i] = 1'b0;
                    req_rst[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic wait_ack(input int i, input int budget);
        bit got = 0;
        for (int c = 0; c < budget && !got; c++) begin
            step();
            if (ack[i]) got = 1;
        end
        chk($sformatf("ack_timeout_%0d", i), int'(got), 1);
    endtask

    task automatic drain(input int budget);
        bit done = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_set[i] && req_rst[i]) begin
                req_set[i] = 1'b0;
                req_rst[i] = 1'b0;
            end
        end
        for (int c = 0; c < budget && !done; c++) begin
            step();
            if (((req_set | req_rst) == '0) && !busy) done = 1;
        end
        chk("drain_timeout", int'(done), 1);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int    sel;
        bit    got;
        int    rr_exp[4];
        rr_exp = '{0, 3, 0, 3};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_s",    int'(s),    0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ack",  int'(ack),  0);
        clear = 1'b0;
        step();

        // Single set on requester 1
        req_set = 4'b0010;
        wait_ack(1, 40);
        steps(3);

        // Clear asserted in the middle of a drive pulse
        req_set = 4'b0001;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            step();
            if (s) got = 1;
        end
        chk("drive_start_timeout", int'(got), 1);
        clear = 1'b1;
        #1;
        chk("clr_s",    int'(s),    0);
        chk("clr_r",    int'(r),    0);
        chk("clr_busy", int'(busy), 0);
        chk("clr_ack",  int'(ack),  0);
        #49;
        clear = 1'b0;

        // Round robin with requests held (re-grant of requester 0 first)
        auto_drop = 0;
        ack_log.delete();
        req_set = 4'b0001;
        req_rst = 4'b1000;
        for (int c = 0; c < 100 && ack_log.size() < 4; c++) step();
        req_set   = '0;
        req_rst   = '0;
        auto_drop = 1;
        chk("rr_count", ack_log.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < ack_log.size()) chk($sformatf("rr_order_%0d", k), ack_log[k], rr_exp[k]);
        end
        drain(50);

        // Conflict on requester 2, then a clean reset request on 1
        req_set = 4'b0100;
        req_rst = 4'b0100;
        steps(5);
        chk("conflict_busy", int'(busy),         0);
        chk("conflict_err",  int'(err_conflict), 1);
        req_rst[1] = 1'b1;
        wait_ack(1, 40);
        req_set[2] = 1'b0;
        req_rst[2] = 1'b0;
        steps(3);

        // Randomized traffic: set/reset/conflict requests and withdrawals
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (req_set[i] && req_rst[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_set[i] = 1'b0;
                        req_rst[i] = 1'b0;
                    end
                end else if (!req_set[i] && !req_rst[i]) begin
                    if ($urandom_range(0, 7) == 0) begin
                        sel = $urandom_range(0, 9);
                        if (sel < 4)      req_set[i] = 1'b1;
                        else if (sel < 8) req_rst[i] = 1'b1;
                        else begin
                            req_set[i] = 1'b1;
                            req_rst[i] = 1'b1;
                        end
                    end
                end else if ($urandom_range(0, 63) == 0) begin
                    req_set[i] = 1'b0;
                    req_rst[i] = 1'b0;
                end
            end
        end
        drain(200);

`ifdef SR_FLAG_VERIFY_EN
        // Readback mismatch: flop output stuck low while setting
        tie_low = 1'b1;
        req_set = 4'b0010;
        wait_ack(1, 40);
        steps(4);
        chk("verify_sticky", int'(verify_err), 1);
        clear = 1'b1;
        #1;
        chk("verify_cleared", int'(verify_err), 0);
        tie_low = 1'b0;
        #9;
        clear = 1'b0;
`endif

        steps(5);
        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
